user_io_ovs: RTL and testbench
==============================

Name: user_io_ovs

Overview:
- Parametrised successor to the IO-controller SPI slave. SPI is oversampled entirely in clk_sys, so the block has no second clock domain.
- Decodes controller commands into:
  - buttons/switches/config,
  - NUM_JOY joysticks of JOY_W bits,
  - an atomic 32-bit status word,
  - a buffered keyboard/mouse event stream with ready/valid handshake, replacing the bare strobe.
- Sits between the MiST IO controller SPI pins and the core.

Parameters:
- NUM_JOY, 2, number of joystick channels (1..6), command codes 0x60..0x60+NUM_JOY-1
- JOY_W, 16, joystick width in bits, multiple of 8, 8..32
- FIFO_DEPTH, 8, event FIFO entries, power of 2, >=2
- SYNC_STAGES, 2, synchroniser flops on spi_clk/spi_ss_io/spi_mosi, >=2

Ports:
- clk_sys  in  1  system clock; must be >= 4x spi_clk frequency
- rst_n  in  1  synchronous active-low reset
- spi_clk  in  1  SPI clock from IO controller (async)
- spi_ss_io  in  1  chip select, active low (async)
- spi_mosi  in  1  SPI data in (async)
- spi_miso  out  1  SPI data out
- spi_miso_oe  out  1  output enable for top-level tristate
- core_type  in  8  returned on byte 0
- joy  out  NUM_JOY*JOY_W  joystick i at [i*JOY_W +: JOY_W]
- buttons  out  2  but_sw[1:0]
- switches  out  2  but_sw[3:2]
- conf  out  4  but_sw[7:4]
- status  out  32  status word
- status_strobe  out  1  1-cycle pulse on status update
- mouse_buttons  out  3  mouse button state
- ev_valid  out  1  event FIFO non-empty
- ev_ready  in  1  consumer accepts head event
- ev_type  out  2  0=mouse X, 1=mouse Y, 2=keycode, 3=OSD key
- ev_data  out  8  event payload
- ev_overflow  out  1  1-cycle pulse when an event is dropped

Behaviour:
- Reset (rst_n=0 at clk_sys edge):
  - All outputs 0, spi_miso_oe=0.
  - FIFO emptied; counters, cmd and shadow status cleared.
- Synchronisation:
  - SYNC_STAGES flops per SPI input; edges are detected on the last two stages.
  - sck_rise: sample mosi into the shift register, bit_cnt++.
  - sck_fall: shift the next MISO bit out.
- Chip select:
  - ss low (synchronised) → spi_miso_oe=1; spi_miso=core_type[7] immediately.
  - Byte 0: MISO shifts core_type MSB first. Later bytes: spi_miso=0.
  - ss high → oe=0; bit_cnt, byte_cnt and cmd cleared; partial byte discarded; shadow status discarded.
- Byte completion:
  - The 8th sck_rise completes a byte. byte_cnt saturates at 255.
  - Decode effect is visible at most SYNC_STAGES+2 clk_sys cycles after the SPI edge.
- Byte 0 latches cmd. Commands:
  - 0x01: byte1 → but_sw.
  - 0x04 mouse:
    - byte1 → event (0,data);
    - byte2 → event (1,data);
    - byte3 → mouse_buttons = data[2:0];
    - later bytes ignored.
  - 0x05: every data byte → event (2,data).
  - 0x06: every data byte → event (3,data).
  - 0x60+i (i<NUM_JOY):
    - bytes 1..JOY_W/8 fill joystick i little-endian, each byte written on arrival;
    - extra bytes ignored;
    - i>=NUM_JOY ignored entirely.
  - 0x1E status:
    - bytes 1..4 fill a shadow little-endian;
    - on byte 4 status <= shadow and status_strobe=1 for one cycle;
    - fewer than 4 bytes → status unchanged, no strobe.
  - Unknown cmd: data ignored.
- Event FIFO:
  - Entry = {type,data}. Head is presented on ev_type/ev_data while ev_valid=1.
  - Pop when ev_valid & ev_ready.
  - Push when full and no pop in the same cycle → event dropped, ev_overflow pulse, contents unchanged.
  - Push and pop in the same cycle when full → both occur, no drop.
  - Push when empty → ev_valid asserts the next cycle (no fall-through).
- rst_n low mid-transfer → immediate reset state. The remainder of the frame is ignored until the next ss falling edge.

Decomposition:
- Shared package user_io_pkg:
  - command codes CMD_BUT_SW=0x01, CMD_MOUSE=0x04, CMD_KBD=0x05, CMD_OSD_KBD=0x06, CMD_STATUS=0x1E, CMD_JOY_BASE=0x60;
  - event type constants EV_MOUSE_X..EV_OSD_KEY.
- One sub-module: user_io_ev_fifo (parametrised synchronous FIFO, width 10, depth FIFO_DEPTH, full/empty, valid/ready read side).

Test Plan:
- Reset, then frame 0x01,0xA5 with spi_clk=clk_sys/8 → buttons=01, switches=01, conf=0xA; MISO bits during byte 0 equal core_type=0xA4 MSB first.
- Frame 0x61,0x34,0x12 (NUM_JOY=2, JOY_W=16) → joy[31:16]=0x1234, joy[15:0] unchanged; frame 0x67,0xFF → no output change.
- Frame 0x04,0x05,0xFB,0x03 with ev_ready=1 → events (0,0x05) then (1,0xFB); mouse_buttons=3'b011.
- ev_ready=0, frame 0x05 + 10 keycodes, FIFO_DEPTH=8 → 8 stored, 2 ev_overflow pulses; then drain → 8 keycodes in order, ev_valid falls.
- Frame 0x1E,0x78,0x56,0x34,0x12 → status=0x12345678 with one status_strobe; frame 0x1E,0x11,0x22 then ss high → status stays 0x12345678, no strobe.
- Assert rst_n=0 mid-byte of a 0x60 frame, release, send 0x60,0x99 → joy[7:0]=0x99 only; no residue from the aborted byte.

Source files
------------

// File: rtl/user_io_pkg.sv
// Shared command codes, event types and the event bundle
// used by the oversampled IO-controller SPI slave.
package user_io_pkg;

  localparam logic [7:0] CMD_BUT_SW   = 8'h01;
  localparam logic [7:0] CMD_MOUSE    = 8'h04;
  localparam logic [7:0] CMD_KBD      = 8'h05;
  localparam logic [7:0] CMD_OSD_KBD  = 8'h06;
  localparam logic [7:0] CMD_STATUS   = 8'h1E;
  localparam logic [7:0] CMD_JOY_BASE = 8'h60;

  typedef enum logic [1:0] {
    EV_MOUSE_X = 2'd0,
    EV_MOUSE_Y = 2'd1,
    EV_KEY     = 2'd2,
    EV_OSD_KEY = 2'd3
  } ev_type_e;

  typedef struct packed {
    ev_type_e   kind;
    logic [7:0] data;
  } ev_t;

endpackage

// File: rtl/user_io_ev_fifo.sv
// Synchronous event FIFO, valid/ready read side, no fall-through.
// Writes into a full FIFO are dropped unless a pop happens in the same cycle.
module user_io_ev_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rdata,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         ovf_q, ovf_d;
  logic         empty, full, pop, wr_en;

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && rd_ready;
    wr_en = push && (!full || pop);
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (wr_en) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d = wr_q + ONE;
    end
    if (pop) begin
      rd_d = rd_q + ONE;
    end
    ovf_d = push && !wr_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  assign rd_valid = !empty;
  assign rdata    = mem_q[rd_q[AW-1:0]];
  assign overflow = ovf_q;

endmodule

// File: rtl/user_io_ovs.sv
// IO-controller SPI slave, oversampled in clk_sys: decodes commands
// into buttons, joysticks, status and a buffered key/mouse event stream.
module user_io_ovs
  import user_io_pkg::*;
#(
  parameter int NUM_JOY     = 2,
  parameter int JOY_W       = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     spi_clk,
  input  logic                     spi_ss_io,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  input  logic [7:0]               core_type,
  output logic [NUM_JOY*JOY_W-1:0] joy,
  output logic [1:0]               buttons,
  output logic [1:0]               switches,
  output logic [3:0]               conf,
  output logic [31:0]              status,
  output logic                     status_strobe,
  output logic [2:0]               mouse_buttons,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_type,
  output logic [7:0]               ev_data,
  output logic                     ev_overflow
);

  localparam int S  = SYNC_STAGES;
  localparam int JB = JOY_W / 8;

  logic [S-1:0] sck_q, sck_d;
  logic [S-1:0] ss_q, ss_d;
  logic [S-1:0] mosi_q, mosi_d;

  logic       active_q, active_d;
  logic       miso_q, miso_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] sr_q, sr_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       byte_vld_q, byte_vld_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] byte_idx_q, byte_idx_d;
  logic [7:0] cmd_q, cmd_d;
  logic [23:0] shadow_q, shadow_d;
  logic [7:0] but_sw_q, but_sw_d;
  logic [NUM_JOY*JOY_W-1:0] joy_q, joy_d;
  logic [31:0] status_q, status_d;
  logic       strobe_q, strobe_d;
  logic [2:0] mbtn_q, mbtn_d;

  logic sck_rise, sck_fall, ss_fall, ss_high, mosi_s;
  logic ev_push;
  ev_t  ev_in, ev_out;

  assign sck_rise = sck_q[S-2] && !sck_q[S-1];
  assign sck_fall = !sck_q[S-2] && sck_q[S-1];
  assign ss_fall  = !ss_q[S-2] && ss_q[S-1];
  assign ss_high  = ss_q[S-2];
  assign mosi_s   = mosi_q[S-1];

  always_comb begin
    sck_d  = {sck_q[S-2:0], spi_clk};
    ss_d   = {ss_q[S-2:0], spi_ss_io};
    mosi_d = {mosi_q[S-2:0], spi_mosi};

    active_d   = active_q;
    miso_d     = miso_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    byte_cnt_d = byte_cnt_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    byte_idx_d = byte_idx_q;
    cmd_d      = cmd_q;
    shadow_d   = shadow_q;
    but_sw_d   = but_sw_q;
    joy_d      = joy_q;
    status_d   = status_q;
    strobe_d   = 1'b0;
    mbtn_d     = mbtn_q;
    ev_push    = 1'b0;
    ev_in      = '0;
    ev_in.data = byte_q;

    // Command decode runs one cycle behind byte completion
    if (byte_vld_q) begin
      if (byte_idx_q == 8'd0) begin
        cmd_d = byte_q;
      end else begin
        unique case (1'b1)
          (cmd_q == CMD_BUT_SW): begin
            if (byte_idx_q == 8'd1) but_sw_d = byte_q;
          end
          (cmd_q == CMD_MOUSE): begin
            case (byte_idx_q)
              8'd1: begin
                ev_push    = 1'b1;
                ev_in.kind = EV_MOUSE_X;
              end
              8'd2: begin
                ev_push    = 1'b1;
                ev_in.kind = EV_MOUSE_Y;
              end
              8'd3:    mbtn_d = byte_q[2:0];
              default: ;
            endcase
          end
          (cmd_q == CMD_KBD): begin
            ev_push    = 1'b1;
            ev_in.kind = EV_KEY;
          end
          (cmd_q == CMD_OSD_KBD): begin
            ev_push    = 1'b1;
            ev_in.kind = EV_OSD_KEY;
          end
          (cmd_q == CMD_STATUS): begin
            case (byte_idx_q)
              8'd1: shadow_d[7:0]   = byte_q;
              8'd2: shadow_d[15:8]  = byte_q;
              8'd3: shadow_d[23:16] = byte_q;
              8'd4: begin
                status_d = {byte_q, shadow_q};
                strobe_d = 1'b1;
              end
              default: ;
            endcase
          end
          default: begin
            for (int i = 0; i < NUM_JOY; i++) begin
              for (int b = 0; b < JB; b++) begin
                if (cmd_q == CMD_JOY_BASE + 8'(i) &&
                    byte_idx_q == 8'(b + 1))
                  joy_d[i*JOY_W + b*8 +: 8] = byte_q;
              end
            end
          end
        endcase
      end
    end

    if (ss_high) begin
      active_d   = 1'b0;
      miso_d     = 1'b0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      cmd_d      = '0;
      shadow_d   = '0;
    end else if (ss_fall) begin
      active_d   = 1'b1;
      miso_d     = core_type[7];
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else if (active_q) begin
      if (sck_rise) begin
        sr_d      = {sr_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_vld_d = 1'b1;
          byte_d     = {sr_q, mosi_s};
          byte_idx_d = byte_cnt_q;
          if (byte_cnt_q != 8'hFF)
            byte_cnt_d = byte_cnt_q + 8'd1;
        end
      end
      // Only byte 0 carries data back: the core type, MSB first
      if (sck_fall)
        miso_d = (byte_cnt_q == 8'd0) ? core_type[~bit_cnt_q] : 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sck_q      <= '0;
      ss_q       <= '0;
      mosi_q     <= '0;
      active_q   <= 1'b0;
      miso_q     <= 1'b0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      byte_cnt_q <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      byte_idx_q <= '0;
      cmd_q      <= '0;
      shadow_q   <= '0;
      but_sw_q   <= '0;
      joy_q      <= '0;
      status_q   <= '0;
      strobe_q   <= 1'b0;
      mbtn_q     <= '0;
    end else begin
      sck_q      <= sck_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      active_q   <= active_d;
      miso_q     <= miso_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      byte_cnt_q <= byte_cnt_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      byte_idx_q <= byte_idx_d;
      cmd_q      <= cmd_d;
      shadow_q   <= shadow_d;
      but_sw_q   <= but_sw_d;
      joy_q      <= joy_d;
      status_q   <= status_d;
      strobe_q   <= strobe_d;
      mbtn_q     <= mbtn_d;
    end
  end

  user_io_ev_fifo #(
    .W     ($bits(ev_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_sys),
    .rst_n    (rst_n),
    .push     (ev_push),
    .wdata    (ev_in),
    .rd_valid (ev_valid),
    .rd_ready (ev_ready),
    .rdata    (ev_out),
    .overflow (ev_overflow)
  );

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = active_q;
  assign joy           = joy_q;
  assign buttons       = but_sw_q[1:0];
  assign switches      = but_sw_q[3:2];
  assign conf          = but_sw_q[7:4];
  assign status        = status_q;
  assign status_strobe = strobe_q;
  assign mouse_buttons = mbtn_q;
  assign ev_type       = ev_out.kind;
  assign ev_data       = ev_out.data;

endmodule

// File: tb/tb_user_io_ovs.sv
// Bench for user_io_ovs: SPI master at clk_sys/8, event scoreboard.
module tb_user_io_ovs;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_ss_io = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        ev_ready = 1'b0;
  logic [7:0]  core_type = 8'hA4;
  logic        spi_miso, spi_miso_oe;
  logic [31:0] joy;
  logic [1:0]  buttons, switches;
  logic [3:0]  conf;
  logic [31:0] status;
  logic        status_strobe;
  logic [2:0]  mouse_buttons;
  logic        ev_valid;
  logic [1:0]  ev_type;
  logic [7:0]  ev_data;
  logic        ev_overflow;

  int n_cmp = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  int stb_cnt = 0;
  logic [9:0] exp_q[$];
  logic [7:0] frm[$];
  logic [7:0] miso0;
  logic       oe_in_frame;

  user_io_ovs dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .spi_clk       (spi_clk),
    .spi_ss_io     (spi_ss_io),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .core_type     (core_type),
    .joy           (joy),
    .buttons       (buttons),
    .switches      (switches),
    .conf          (conf),
    .status        (status),
    .status_strobe (status_strobe),
    .mouse_buttons (mouse_buttons),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_type       (ev_type),
    .ev_data       (ev_data),
    .ev_overflow   (ev_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Scoreboard: the handshake seen here completes on the next rising edge
  always @(negedge clk_sys) begin
    logic [9:0] e;
    #1;
    if (ev_overflow) ovf_cnt++;
    if (status_strobe) stb_cnt++;
    if (ev_valid && ev_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ev_unexpected got=%0d/%h want=none",
                 ev_type, ev_data);
      end else begin
        e = exp_q.pop_front();
        if ({ev_type, ev_data} !== e) begin
          n_err++;
          $display("FAIL ev_order got=%0d/%h want=%0d/%h",
                   ev_type, ev_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic spi_bit(input logic b, output logic mi);
    spi_mosi = b;
    wait_clk(4);
    mi = spi_miso;
    spi_clk = 1'b1;
    wait_clk(4);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], mi[i]);
  endtask

  task automatic send_frame();
    logic [7:0] mi;
    spi_ss_io = 1'b0;
    wait_clk(8);
    oe_in_frame = spi_miso_oe;
    foreach (frm[i]) begin
      spi_byte(frm[i], mi);
      if (i == 0) miso0 = mi;
    end
    wait_clk(4);
    spi_ss_io = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(4);
    n_cmp++;
    if ({spi_miso, spi_miso_oe, buttons, switches, conf, status_strobe,
         mouse_buttons, ev_valid, ev_type, ev_data, ev_overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_ctl miso=%b oe=%b but=%b sw=%b conf=%h ev=%b want all 0",
               spi_miso, spi_miso_oe, buttons, switches, conf, ev_valid);
    end
    n_cmp++;
    if (joy !== 32'h0) begin
      n_err++;
      $display("FAIL reset_joy got=%h want=0", joy);
    end
    n_cmp++;
    if (status !== 32'h0) begin
      n_err++;
      $display("FAIL reset_status got=%h want=0", status);
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_but_sw();
    frm.delete();
    frm.push_back(8'h01);
    frm.push_back(8'hA5);
    send_frame();
    n_cmp++;
    if (miso0 !== 8'hA4) begin
      n_err++;
      $display("FAIL miso_core_type got=%h want=a4", miso0);
    end
    n_cmp++;
    if (oe_in_frame !== 1'b1) begin
      n_err++;
      $display("FAIL oe_in_frame got=%b want=1", oe_in_frame);
    end
    n_cmp++;
    if (spi_miso_oe !== 1'b0) begin
      n_err++;
      $display("FAIL oe_after_frame got=%b want=0", spi_miso_oe);
    end
    n_cmp++;
    if (buttons !== 2'b01) begin
      n_err++;
      $display("FAIL buttons got=%b want=01", buttons);
    end
    n_cmp++;
    if (switches !== 2'b01) begin
      n_err++;
      $display("FAIL switches got=%b want=01", switches);
    end
    n_cmp++;
    if (conf !== 4'hA) begin
      n_err++;
      $display("FAIL conf got=%h want=a", conf);
    end
  endtask

  task automatic test_joy();
    frm.delete();
    frm.push_back(8'h61);
    frm.push_back(8'h34);
    frm.push_back(8'h12);
    send_frame();
    n_cmp++;
    if (joy !== 32'h1234_0000) begin
      n_err++;
      $display("FAIL joy1 got=%h want=12340000", joy);
    end
    frm.delete();
    frm.push_back(8'h67);
    frm.push_back(8'hFF);
    send_frame();
    n_cmp++;
    if (joy !== 32'h1234_0000) begin
      n_err++;
      $display("FAIL joy_bad_index got=%h want=12340000", joy);
    end
    frm.delete();
    frm.push_back(8'h60);
    frm.push_back(8'hAA);
    frm.push_back(8'hBB);
    frm.push_back(8'hCC);
    send_frame();
    n_cmp++;
    if (joy !== 32'h1234_BBAA) begin
      n_err++;
      $display("FAIL joy0_extra got=%h want=1234bbaa", joy);
    end
  endtask

  task automatic test_mouse();
    ev_ready = 1'b1;
    exp_q.push_back({2'd0, 8'h05});
    exp_q.push_back({2'd1, 8'hFB});
    frm.delete();
    frm.push_back(8'h04);
    frm.push_back(8'h05);
    frm.push_back(8'hFB);
    frm.push_back(8'h03);
    frm.push_back(8'h77);
    send_frame();
    wait_clk(10);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mouse_events left=%0d want=0", exp_q.size());
    end
    n_cmp++;
    if (mouse_buttons !== 3'b011) begin
      n_err++;
      $display("FAIL mouse_buttons got=%b want=011", mouse_buttons);
    end
  endtask

  task automatic test_back_to_back();
    ev_ready = 1'b1;
    frm.delete();
    frm.push_back(8'h06);
    for (int i = 0; i < 3; i++) begin
      frm.push_back(8'h81 + 8'(i));
      exp_q.push_back({2'd3, 8'h81 + 8'(i)});
    end
    send_frame();
    wait_clk(10);
    n_cmp++;
    if (exp_q.size() != 0 || ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL osd_events left=%0d valid=%b want=0/0",
               exp_q.size(), ev_valid);
    end
  endtask

  task automatic test_overflow();
    int o0;
    int k;
    ev_ready = 1'b0;
    o0 = ovf_cnt;
    frm.delete();
    frm.push_back(8'h05);
    for (int i = 0; i < 10; i++) begin
      frm.push_back(8'h10 + 8'(i));
      if (i < 8) exp_q.push_back({2'd2, 8'h10 + 8'(i)});
    end
    send_frame();
    n_cmp++;
    if (ovf_cnt - o0 != 2) begin
      n_err++;
      $display("FAIL overflow_pulses got=%0d want=2", ovf_cnt - o0);
    end
    n_cmp++;
    if (ev_valid !== 1'b1) begin
      n_err++;
      $display("FAIL full_valid got=%b want=1", ev_valid);
    end
    ev_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || ev_valid) && k < 100) begin
      wait_clk(1);
      k++;
    end
    wait_clk(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_left got=%0d want=0", exp_q.size());
    end
    n_cmp++;
    if (ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_valid got=%b want=0", ev_valid);
    end
  endtask

  task automatic test_status();
    int s0;
    s0 = stb_cnt;
    frm.delete();
    frm.push_back(8'h1E);
    frm.push_back(8'h78);
    frm.push_back(8'h56);
    frm.push_back(8'h34);
    frm.push_back(8'h12);
    send_frame();
    n_cmp++;
    if (status !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL status got=%h want=12345678", status);
    end
    n_cmp++;
    if (stb_cnt - s0 != 1) begin
      n_err++;
      $display("FAIL status_strobe got=%0d want=1", stb_cnt - s0);
    end
    s0 = stb_cnt;
    frm.delete();
    frm.push_back(8'h1E);
    frm.push_back(8'h11);
    frm.push_back(8'h22);
    send_frame();
    n_cmp++;
    if (status !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL status_short got=%h want=12345678", status);
    end
    n_cmp++;
    if (stb_cnt - s0 != 0) begin
      n_err++;
      $display("FAIL status_short_strobe got=%0d want=0", stb_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    logic       b;
    logic [7:0] ab;
    ab = 8'hAB;
    spi_ss_io = 1'b0;
    wait_clk(8);
    spi_byte(8'h60, mi);
    for (int i = 7; i >= 4; i--) spi_bit(ab[i], b);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    n_cmp++;
    if (spi_miso_oe !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_oe got=%b want=0", spi_miso_oe);
    end
    for (int i = 3; i >= 0; i--) spi_bit(ab[i], b);
    spi_byte(8'h55, mi);
    n_cmp++;
    if (joy !== 32'h0 || spi_miso_oe !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_ignored joy=%h oe=%b want=0/0",
               joy, spi_miso_oe);
    end
    wait_clk(4);
    spi_ss_io = 1'b1;
    wait_clk(8);
    frm.delete();
    frm.push_back(8'h60);
    frm.push_back(8'h99);
    send_frame();
    n_cmp++;
    if (joy !== 32'h0000_0099) begin
      n_err++;
      $display("FAIL rst_mid_joy got=%h want=00000099", joy);
    end
  endtask

  initial begin
    test_reset();
    test_but_sw();
    test_joy();
    test_mouse();
    test_back_to_back();
    test_overflow();
    test_status();
    test_reset_mid();
    wait_clk(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
